// File: rtl/cpu_run_ctrl.sv
// Run controller for the 8-bit core. It loads the program image into RAM,
// then gates core execution with free-run, single-step and halt.
module cpu_run_ctrl #(
  parameter int                ADDR_W      = 6,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] HALT_OP     = 8'hFF,
  parameter int                STEP_CYCLES = 3,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  output logic              host_ready,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] opcode_in,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              ovf
);

  localparam int SC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    STEP  = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] load_ptr_q;
  logic [CNT_W-1:0]  cycle_cnt_q;
  logic              ovf_q;
  logic [SC_W-1:0]   step_cnt_q;

  logic xfer;
  logic halt_fetch;
  logic ptr_max;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign xfer       = (state_q == LOAD) && host_valid;
  assign halt_fetch = (opcode_in == HALT_OP);
  assign ptr_max    = (load_ptr_q == {ADDR_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      load_ptr_q  <= '0;
      cycle_cnt_q <= '0;
      ovf_q       <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      if (state_q == RUN || state_q == STEP)
        cycle_cnt_q <= sat_inc(cycle_cnt_q);
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q     <= LOAD;
            load_ptr_q  <= '0;
            ovf_q       <= 1'b0;
            cycle_cnt_q <= '0;
          end
        end
        LOAD: begin
          // The pointer parks on the last address instead of wrapping.
          if (host_valid) begin
            if (!ptr_max)
              load_ptr_q <= load_ptr_q + ADDR_W'(1);
            if (host_last) begin
              state_q <= READY;
            end else if (ptr_max) begin
              ovf_q   <= 1'b1;
              state_q <= READY;
            end
          end
        end
        READY, HALT: begin
          if (halt_req) begin
            state_q <= HALT;
          end else if (load_start) begin
            state_q     <= LOAD;
            load_ptr_q  <= '0;
            ovf_q       <= 1'b0;
            cycle_cnt_q <= '0;
          end else if (run_req) begin
            state_q <= RUN;
          end else if (step_req) begin
            state_q    <= STEP;
            step_cnt_q <= SC_W'(STEP_CYCLES - 1);
          end
        end
        RUN: begin
          // A load request while running only stops the core.
          if (halt_req || halt_fetch || load_start)
            state_q <= HALT;
        end
        STEP: begin
          if (halt_req || halt_fetch)
            state_q <= HALT;
          else if (step_cnt_q == '0)
            state_q <= READY;
          else
            step_cnt_q <= step_cnt_q - SC_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign host_ready = (state_q == LOAD);
  assign ram_we     = xfer;
  assign ram_wdata  = xfer ? host_data : '0;
  assign ram_addr   = (state_q == LOAD) ? load_ptr_q :
                      (state_q == IDLE) ? '0 : pc_in;
  assign cpu_rst    = (state_q == IDLE) || (state_q == LOAD);
  assign cpu_en     = (state_q == RUN) || (state_q == STEP);
  assign state_o    = state_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: load, overflow, run, step, halt and
// request priority, with expected values written out by hand.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, host_valid, host_last, host_ready;
  logic [7:0]  host_data;
  logic        run_req, step_req, halt_req;
  logic [5:0]  pc_in;
  logic [7:0]  opcode_in;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        cpu_rst, cpu_en;
  logic [2:0]  state_o;
  logic [15:0] cycle_cnt;
  logic        ovf;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] prog [4] = '{8'h01, 8'h02, 8'h03, 8'hFF};

  cpu_run_ctrl dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .host_valid(host_valid), .host_data(host_data),
    .host_last(host_last), .host_ready(host_ready),
    .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .pc_in(pc_in), .opcode_in(opcode_in),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; load_start = 0; host_valid = 0; host_data = 0; host_last = 0;
    run_req = 0; step_req = 0; halt_req = 0; pc_in = 0; opcode_in = 0;
    #3;
    check("rst_state", state_o, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_ready", host_ready, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_cnt", cycle_cnt, 0);
    check("rst_ovf", ovf, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // IDLE ignores run requests
    run_req = 1; cyc(); run_req = 0;
    check("idle_ignore_run", state_o, 0);

    // Reset in the middle of a load
    load_start = 1; cyc(); load_start = 0;
    check("load_state", state_o, 1);
    check("load_ready", host_ready, 1);
    check("load_cpu_rst", cpu_rst, 1);
    for (int i = 0; i < 3; i++) begin
      host_valid = 1; host_data = 8'hA0 + 8'(i); #1;
      check("pre_rst_addr", ram_addr, i);
      check("pre_rst_we", ram_we, 1);
      cyc();
    end
    host_valid = 0;
    rst = 1'b1; #1;
    check("midrst_state", state_o, 0);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_ready", host_ready, 0);
    check("midrst_addr", ram_addr, 0);
    rst = 1'b0;
    cyc();

    // Reload 4 bytes; a stray load_start mid-transfer must be ignored
    load_start = 1; cyc(); load_start = 0;
    for (int i = 0; i < 4; i++) begin
      host_valid = 1; host_data = prog[i]; host_last = (i == 3);
      load_start = (i == 1); #1;
      check("ld_we", ram_we, 1);
      check("ld_addr", ram_addr, i);
      check("ld_data", ram_wdata, prog[i]);
      cyc();
    end
    host_valid = 0; host_last = 0; load_start = 0; #1;
    check("ld_done_state", state_o, 2);
    check("ld_done_we", ram_we, 0);
    check("ld_done_ready", host_ready, 0);
    check("ld_done_cpu_rst", cpu_rst, 0);
    check("ld_done_ovf", ovf, 0);
    pc_in = 6'd2; #1;
    check("ready_addr_pc", ram_addr, 2);

    // Free-run until the HALT opcode is fetched at pc 3
    pc_in = 0; opcode_in = 8'h01;
    run_req = 1; cyc(); run_req = 0;
    check("run_state", state_o, 3);
    check("run_en", cpu_en, 1);
    for (int i = 0; i < 4; i++) begin
      pc_in = 6'(i); opcode_in = prog[i]; step_req = (i == 1); #1;
      check("run_en_loop", cpu_en, 1);
      check("run_addr", ram_addr, i);
      cyc();
    end
    step_req = 0; opcode_in = 8'h01;
    check("halt_op_state", state_o, 5);
    check("halt_op_en", cpu_en, 0);
    check("halt_op_cnt", cycle_cnt, 4);

    // Single step from HALT, then from READY
    for (int r = 0; r < 2; r++) begin
      step_req = 1; cyc(); step_req = 0;
      for (int k = 0; k < 3; k++) begin
        check("step_state", state_o, 4);
        check("step_en", cpu_en, 1);
        cyc();
      end
      check("step_back_ready", state_o, 2);
      check("step_back_en", cpu_en, 0);
      check("step_cnt", cycle_cnt, 7 + 3 * r);
    end

    // halt_req on the second step cycle
    step_req = 1; cyc(); step_req = 0;
    cyc();
    halt_req = 1; #1;
    check("step2_en", cpu_en, 1);
    cyc(); halt_req = 0;
    check("step_halt_state", state_o, 5);
    check("step_halt_en", cpu_en, 0);
    check("step_halt_cnt", cycle_cnt, 12);

    // Reload from HALT, overflowing the image with 65 bytes
    load_start = 1; cyc(); load_start = 0;
    check("reload_state", state_o, 1);
    check("reload_cpu_rst", cpu_rst, 1);
    check("reload_cnt", cycle_cnt, 0);
    for (int i = 0; i < 65; i++) begin
      host_valid = 1; host_data = 8'(i); pc_in = 6'd9; #1;
      if (i < 64) begin
        check("ovf_we", ram_we, 1);
        check("ovf_addr", ram_addr, i);
      end else begin
        check("ovf_65_ready", host_ready, 0);
        check("ovf_65_we", ram_we, 0);
      end
      cyc();
    end
    host_valid = 0;
    check("ovf_flag", ovf, 1);
    check("ovf_state", state_o, 2);

    // Priority: halt beats run in READY, then run alone
    halt_req = 1; run_req = 1; cyc(); halt_req = 0; run_req = 0;
    check("prio_halt", state_o, 5);
    run_req = 1; cyc(); run_req = 0;
    check("prio_run", state_o, 3);
    check("prio_run_en", cpu_en, 1);

    // load_start while running only halts
    load_start = 1; cyc(); load_start = 0;
    check("run_load_halts", state_o, 5);
    check("run_load_cpu_rst", cpu_rst, 0);
    check("ovf_kept", ovf, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
